// File: rtl/sme_result_wb.sv
// Writeback buffer between the SME result pipeline and the host register-file write port.
// In-order circular FIFO with a pending-write hazard query over the occupied entries.
module sme_result_wb #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                         g_clk,
  input  logic                         g_resetn,
  input  logic                         sme_res_valid,
  output logic                         sme_res_ready,
  input  logic [XLEN+3:0]              sme_res,
  output logic                         host_wb_valid,
  input  logic                         host_wb_ready,
  output logic [XLEN-1:0]              host_wb_wdata,
  output logic [3:0]                   host_wb_addr,
  input  logic                         flush,
  input  logic [3:0]                   hzd_addr,
  output logic                         hzd_pending,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] r_data [DEPTH];
  logic [3:0]      r_addr [DEPTH];
  logic [PW-1:0]   r_rptr;
  logic [PW-1:0]   r_wptr;
  logic [CW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;
  logic            w_hzd;
  logic [PW-1:0]   w_offs;

  assign sme_res_ready = !flush && (r_count != CW'(DEPTH));
  assign host_wb_valid = (r_count != '0);
  assign w_push        = sme_res_valid && sme_res_ready;
  assign w_pop         = host_wb_valid && host_wb_ready;

  assign host_wb_wdata = r_data[r_rptr];
  assign host_wb_addr  = r_addr[r_rptr];
  assign count         = r_count;
  assign hzd_pending   = w_hzd;

  // An entry is occupied when its distance past the read pointer is below the count.
  always_comb begin
    w_hzd  = 1'b0;
    w_offs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_offs = PW'(i) - r_rptr;
      if ((CW'(w_offs) < r_count) && (r_addr[i] == hzd_addr))
        w_hzd = 1'b1;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rptr  <= r_wptr;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PW'(1);
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge g_clk) begin
    if (w_push) begin
      r_data[r_wptr] <= sme_res[XLEN+3:4];
      r_addr[r_wptr] <= sme_res[3:0];
    end
  end

endmodule

// File: tb/tb_sme_result_wb.sv
// Directed and randomized bench for sme_result_wb, checked against a queue model
// of the buffer contents.
module tb_sme_result_wb;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic              g_clk;
  logic              g_resetn;
  logic              sme_res_valid;
  logic              sme_res_ready;
  logic [XLEN+3:0]   sme_res;
  logic              host_wb_valid;
  logic              host_wb_ready;
  logic [XLEN-1:0]   host_wb_wdata;
  logic [3:0]        host_wb_addr;
  logic              flush;
  logic [3:0]        hzd_addr;
  logic              hzd_pending;
  logic [1:0]        count;

  sme_result_wb #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .g_clk         (g_clk),
    .g_resetn      (g_resetn),
    .sme_res_valid (sme_res_valid),
    .sme_res_ready (sme_res_ready),
    .sme_res       (sme_res),
    .host_wb_valid (host_wb_valid),
    .host_wb_ready (host_wb_ready),
    .host_wb_wdata (host_wb_wdata),
    .host_wb_addr  (host_wb_addr),
    .flush         (flush),
    .hzd_addr      (hzd_addr),
    .hzd_pending   (hzd_pending),
    .count         (count)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [35:0] q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_hzd;
    exp_hzd = 1'b0;
    foreach (q[k]) if (q[k][3:0] == hzd_addr) exp_hzd = 1'b1;
    chk("count", 64'(count), 64'(q.size()));
    chk("wb_valid", 64'(host_wb_valid), 64'(q.size() != 0));
    chk("res_ready", 64'(sme_res_ready), 64'(!flush && (q.size() < DEPTH)));
    chk("hzd_pending", 64'(hzd_pending), 64'(exp_hzd));
    if (q.size() != 0) begin
      chk("wb_wdata", 64'(host_wb_wdata), 64'(q[0][35:4]));
      chk("wb_addr", 64'(host_wb_addr), 64'(q[0][3:0]));
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] a,
                      input logic rdy, input logic fl, input logic [3:0] hz);
    logic m_push, m_pop;
    @(negedge g_clk);
    sme_res_valid = v;
    sme_res       = {d, a};
    host_wb_ready = rdy;
    flush         = fl;
    hzd_addr      = hz;
    #1 check_outputs();
    @(posedge g_clk);
    m_push = v && !fl && (q.size() < DEPTH);
    m_pop  = (q.size() != 0) && rdy;
    if (m_pop) void'(q.pop_front());
    if (fl) q.delete();
    else if (m_push) q.push_back({d, a});
  endtask

  // Idle inputs so the following edge changes nothing; only hzd_addr is applied.
  task automatic peek(input logic [3:0] hz);
    @(negedge g_clk);
    sme_res_valid = 1'b0;
    host_wb_ready = 1'b0;
    flush         = 1'b0;
    hzd_addr      = hz;
    #1;
  endtask

  initial begin
    g_resetn      = 1'b0;
    sme_res_valid = 1'b0;
    sme_res       = '0;
    host_wb_ready = 1'b0;
    flush         = 1'b0;
    hzd_addr      = 4'h0;
    repeat (2) @(negedge g_clk);
    #1 check_outputs();
    chk("rst_ready", 64'(sme_res_ready), 64'd1);
    @(negedge g_clk);
    g_resetn = 1'b1;

    // single beat
    step(1'b1, 32'hDEADBEEF, 4'h5, 1'b0, 1'b0, 4'h5);
    peek(4'h5);
    chk("single_valid", 64'(host_wb_valid), 64'd1);
    chk("single_wdata", 64'(host_wb_wdata), 64'hDEADBEEF);
    chk("single_addr", 64'(host_wb_addr), 64'h5);
    chk("single_count", 64'(count), 64'd1);
    chk("single_hzd", 64'(hzd_pending), 64'd1);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h5);
    peek(4'h5);
    chk("single_drained", 64'(count), 64'd0);

    // fill and back-pressure
    step(1'b1, 32'h1111_0001, 4'h1, 1'b0, 1'b0, 4'h0);
    step(1'b1, 32'h2222_0002, 4'h2, 1'b0, 1'b0, 4'h0);
    step(1'b1, 32'h3333_0003, 4'h3, 1'b0, 1'b0, 4'h0);
    peek(4'h0);
    chk("full_ready", 64'(sme_res_ready), 64'd0);
    chk("full_count", 64'(count), 64'd2);
    chk("full_head", 64'(host_wb_addr), 64'h1);
    step(1'b1, 32'h3333_0003, 4'h3, 1'b1, 1'b0, 4'h0);
    step(1'b1, 32'h3333_0003, 4'h3, 1'b1, 1'b0, 4'h0);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h0);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h0);

    // streaming with one entry resident
    step(1'b1, 32'hA000_0000, 4'h0, 1'b0, 1'b0, 4'h0);
    for (int i = 1; i < 8; i++)
      step(1'b1, 32'hA000_0000 + 32'(i), 4'(i), 1'b1, 1'b0, 4'(i));
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h7);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h7);

    // hazard query
    step(1'b1, 32'h0000_0303, 4'h3, 1'b0, 1'b0, 4'h0);
    step(1'b1, 32'h0000_0909, 4'h9, 1'b0, 1'b0, 4'h0);
    peek(4'h9);
    chk("hzd_hit9", 64'(hzd_pending), 64'd1);
    peek(4'h4);
    chk("hzd_miss4", 64'(hzd_pending), 64'd0);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h3);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h9);
    peek(4'h3);
    chk("hzd_gone3", 64'(hzd_pending), 64'd0);

    // flush with concurrent pop
    step(1'b1, 32'hF00D_0001, 4'hA, 1'b0, 1'b0, 4'h0);
    step(1'b1, 32'hF00D_0002, 4'hB, 1'b0, 1'b0, 4'h0);
    step(1'b1, 32'hF00D_0003, 4'hC, 1'b1, 1'b1, 4'hB);
    peek(4'hB);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(host_wb_valid), 64'd0);
    chk("flush_hzd", 64'(hzd_pending), 64'd0);

    // async reset between edges
    step(1'b1, 32'hCAFE_0001, 4'h6, 1'b0, 1'b0, 4'h0);
    step(1'b1, 32'hCAFE_0002, 4'h7, 1'b0, 1'b0, 4'h6);
    peek(4'h6);
    chk("prerst_count", 64'(count), 64'd2);
    #2 g_resetn = 1'b0;
    #1;
    q.delete();
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(host_wb_valid), 64'd0);
    chk("arst_hzd", 64'(hzd_pending), 64'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    step(1'b1, 32'h1234_5678, 4'hE, 1'b0, 1'b0, 4'hE);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'hE);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, 32'($urandom), 4'($urandom), ($urandom % 3) != 0,
           ($urandom % 20) == 0, 4'($urandom));
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h0);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h0);
    peek(4'h0);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
